// File: rtl/register_v3.sv
// register_v3: SPI-driven management register controller.
// Decodes SPI commands into one-hot requests to NUM_PORTS MAC blocks, gathers
// multi-byte read responses into rdata, and stages flow-table entries/hashes.
// Optional feature: define REG_TIMEOUT_EN to abort stalled reads after
// TIMEOUT_CYCLES cycles in WAIT (sets err and tmo).
module register_v3 #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned MGNT_REG_WIDTH = 32,
    parameter int unsigned FLOW_WIDTH     = 120,
    parameter int unsigned HASH_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_wr,
    input  logic [6:0]                spi_op,
    input  logic [15:0]               spi_din,
    output logic                      spi_ack,
    output logic [15:0]               spi_dout,
    output logic [NUM_PORTS-1:0]      sys_req_valid,
    output logic                      sys_req_wr,
    output logic [7:0]                sys_req_addr,
    input  logic                      sys_resp_valid,
    input  logic [7:0]                sys_resp_data,
    output logic                      ft_update,
    output logic                      ft_clear,
    output logic [FLOW_WIDTH-1:0]     flow,
    output logic [HASH_WIDTH-1:0]     hash
);

    localparam int unsigned NBYTES = MGNT_REG_WIDTH / 8;
    localparam int unsigned NW     = MGNT_REG_WIDTH / 16;
    localparam int unsigned NFW    = (FLOW_WIDTH + 15) / 16;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      wr_q;
    logic [2:0]                port_q;
    logic [7:0]                byte_cnt;
    logic [MGNT_REG_WIDTH-1:0] shreg;
    logic [MGNT_REG_WIDTH-1:0] rdata;
    logic                      err;
    logic                      tmo;
    logic                      timeout_c;

    logic                      cmd_c;
    logic                      accept_c;
    logic                      reject_c;
    logic                      last_byte_c;
    logic                      tmo_evt_c;
    logic                      busy_c;
    logic [NUM_PORTS-1:0]      req_valid_c;
    logic                      req_wr_c;

    // Command decode: accept only when idle and the port exists
    assign cmd_c       = spi_wr && (spi_op == 7'h00);
    assign accept_c    = cmd_c && (state == S_IDLE) && (spi_din[14:8] < 7'(NUM_PORTS));
    assign reject_c    = cmd_c && !accept_c;
    assign last_byte_c = (state == S_WAIT) && sys_resp_valid && (byte_cnt == 8'(NBYTES - 1));
    assign tmo_evt_c   = (state == S_WAIT) && timeout_c && !last_byte_c;
    assign busy_c      = (state != S_IDLE);

`ifdef REG_TIMEOUT_EN
    logic [15:0] timer;

    assign timeout_c = (timer == 16'(TIMEOUT_CYCLES - 1));

    // WAIT timer, restarted on every read issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
            tmo   <= 1'b0;
        end else begin
            if (state == S_ISSUE) timer <= '0;
            else if (state == S_WAIT) timer <= timer + 16'd1;
            if (accept_c) tmo <= 1'b0;
            else if (tmo_evt_c) tmo <= 1'b1;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign tmo       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a completing byte wins over a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_c) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = wr_q ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (last_byte_c)    state_nxt = S_DONE;
                else if (timeout_c) state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: request pulse values registered one cycle later
    always_comb begin
        req_valid_c = '0;
        req_wr_c    = 1'b0;
        if (state == S_ISSUE) begin
            req_valid_c = NUM_PORTS'(1) << port_q;
            req_wr_c    = wr_q;
        end
    end

    // Management datapath: request outputs, byte gathering, status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_ack       <= 1'b0;
            sys_req_valid <= '0;
            sys_req_wr    <= 1'b0;
            sys_req_addr  <= '0;
            wr_q          <= 1'b0;
            port_q        <= '0;
            byte_cnt      <= '0;
            shreg         <= '0;
            rdata         <= '0;
            err           <= 1'b0;
        end else begin
            spi_ack       <= spi_wr;
            sys_req_valid <= req_valid_c;
            sys_req_wr    <= req_wr_c;
            if (accept_c) begin
                wr_q         <= spi_din[15];
                port_q       <= spi_din[10:8];
                sys_req_addr <= spi_din[7:0];
            end
            if (accept_c) err <= 1'b0;
            else if (reject_c || tmo_evt_c) err <= 1'b1;
            if (state == S_ISSUE && !wr_q) begin
                byte_cnt <= '0;
            end else if (state == S_WAIT && sys_resp_valid) begin
                byte_cnt <= byte_cnt + 8'd1;
                shreg    <= {shreg[MGNT_REG_WIDTH-9:0], sys_resp_data};
            end
            if (state == S_DONE) rdata <= shreg;
        end
    end

    // Flow-table staging and strobes, independent of the management FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ft_update <= 1'b0;
            ft_clear  <= 1'b0;
            flow      <= '0;
            hash      <= '0;
        end else begin
            ft_update <= spi_wr && (spi_op == 7'h02) && (spi_din == 16'h0001);
            ft_clear  <= spi_wr && (spi_op == 7'h02) && (spi_din == 16'h0002);
            if (spi_wr && spi_op == 7'h03) hash <= spi_din[HASH_WIDTH-1:0];
            for (int k = 0; k < int'(NFW); k++) begin
                if (spi_wr && spi_op == 7'(48 + k)) begin
                    flow <= (flow & ~(FLOW_WIDTH'(16'hFFFF) << (16 * k)))
                          | (FLOW_WIDTH'(spi_din) << (16 * k));
                end
            end
        end
    end

    // Combinational read mux
    always_comb begin
        spi_dout = '0;
        if (spi_op == 7'h0F) spi_dout = {busy_c, err, tmo, 5'b0, byte_cnt};
        for (int k = 0; k < int'(NW); k++) begin
            if (spi_op == 7'(16 + k)) spi_dout = rdata[16*k +: 16];
        end
    end

endmodule

// File: tb/tb_register_v3.sv
// Testbench for register_v3: scoreboard queues for requests, acks and
// flow-table strobes; direct checks for read-mux values and staged data.
module tb_register_v3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         spi_wr = 1'b0;
    logic [6:0]   spi_op = 7'h0F;
    logic [15:0]  spi_din = '0;
    logic         spi_ack;
    logic [15:0]  spi_dout;
    logic [3:0]   sys_req_valid;
    logic         sys_req_wr;
    logic [7:0]   sys_req_addr;
    logic         sys_resp_valid = 1'b0;
    logic [7:0]   sys_resp_data = '0;
    logic         ft_update;
    logic         ft_clear;
    logic [119:0] flow;
    logic [11:0]  hash;

    register_v3 #(
        .NUM_PORTS(4), .MGNT_REG_WIDTH(32), .FLOW_WIDTH(120),
        .HASH_WIDTH(12), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .spi_wr(spi_wr), .spi_op(spi_op), .spi_din(spi_din),
        .spi_ack(spi_ack), .spi_dout(spi_dout), .sys_req_valid(sys_req_valid),
        .sys_req_wr(sys_req_wr), .sys_req_addr(sys_req_addr),
        .sys_resp_valid(sys_resp_valid), .sys_resp_data(sys_resp_data),
        .ft_update(ft_update), .ft_clear(ft_clear), .flow(flow), .hash(hash)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {int cyc; logic [3:0] oh; logic wr; logic [7:0] addr;} req_t;
    typedef struct {int cyc; logic upd; logic clr;} ft_t;
    req_t req_q[$];
    ft_t  ft_q[$];
    int   ack_q[$];
    req_t re;
    ft_t  fe;
    int   ae;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm, input int exp_cyc);
        checks++;
        failures++;
        $display("FAIL %s expected at cycle %0d, not seen by cycle %0d", nm, exp_cyc, cyc);
    endtask

    // Monitor: pop and compare whenever the DUT presents an event
    always @(negedge clk) begin
        if (!rst) begin
            while (req_q.size() > 0 && req_q[0].cyc < cyc) begin miss("req_missing", req_q[0].cyc); void'(req_q.pop_front()); end
            while (ft_q.size()  > 0 && ft_q[0].cyc  < cyc) begin miss("ft_missing", ft_q[0].cyc);   void'(ft_q.pop_front());  end
            while (ack_q.size() > 0 && ack_q[0]     < cyc) begin miss("ack_missing", ack_q[0]);     void'(ack_q.pop_front()); end
            if (sys_req_valid != 4'b0) begin
                if (req_q.size() == 0) chk("req_unexpected", {sys_req_valid, sys_req_wr, sys_req_addr}, 0);
                else begin
                    re = req_q.pop_front();
                    chk("req_cycle", cyc, re.cyc);
                    chk("req_onehot", sys_req_valid, re.oh);
                    chk("req_wr", sys_req_wr, re.wr);
                    chk("req_addr", sys_req_addr, re.addr);
                end
            end
            if (ft_update || ft_clear) begin
                if (ft_q.size() == 0) chk("ft_unexpected", {ft_update, ft_clear}, 0);
                else begin
                    fe = ft_q.pop_front();
                    chk("ft_cycle", cyc, fe.cyc);
                    chk("ft_strobes", {ft_update, ft_clear}, {fe.upd, fe.clr});
                end
            end
            if (spi_ack) begin
                if (ack_q.size() == 0) chk("ack_unexpected", spi_ack, 0);
                else begin
                    ae = ack_q.pop_front();
                    chk("ack_cycle", cyc, ae);
                end
            end
        end
    end

    // One cycle of input drive
    task automatic step(input logic w, input logic [6:0] op, input logic [15:0] din,
                        input logic rv, input logic [7:0] rd);
        @(posedge clk);
        #1;
        spi_wr = w; spi_op = op; spi_din = din;
        sys_resp_valid = rv; sys_resp_data = rd;
        if (w) ack_q.push_back(cyc + 1);
    endtask

    task automatic idle();
        step(1'b0, 7'h7F, 16'h0, 1'b0, 8'h0);
    endtask

    task automatic resp(input logic [7:0] b);
        step(1'b0, 7'h7F, 16'h0, 1'b1, b);
    endtask

    task automatic cmd(input logic [15:0] din, input logic acc, input logic [3:0] oh);
        req_t r;
        step(1'b1, 7'h00, din, 1'b0, 8'h0);
        if (acc) begin
            r.cyc = cyc + 2; r.oh = oh; r.wr = din[15]; r.addr = din[7:0];
            req_q.push_back(r);
        end
    endtask

    task automatic ftw(input logic [15:0] din, input logic upd, input logic clr);
        ft_t f;
        step(1'b1, 7'h02, din, 1'b0, 8'h0);
        if (upd || clr) begin
            f.cyc = cyc + 1; f.upd = upd; f.clr = clr;
            ft_q.push_back(f);
        end
    endtask

    task automatic rd(input logic [6:0] op, input logic [15:0] exp, input string nm);
        step(1'b0, op, 16'h0, 1'b0, 8'h0);
        @(negedge clk);
        chk(nm, spi_dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_req_valid", sys_req_valid, 0);
        chk("rst_ack", spi_ack, 0);
        chk("rst_ft", {ft_update, ft_clear}, 0);
        chk("rst_flow", flow, 0);
        chk("rst_hash", hash, 0);
        chk("rst_status", spi_dout, 16'h0000);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Read from port 1, addr 0x12
        cmd(16'h0112, 1'b1, 4'b0010);
        idle();
        resp(8'hDE);
        resp(8'hAD);
        rd(7'h0F, 16'h8002, "rd1_status_mid");
        resp(8'hBE);
        resp(8'hEF);
        rd(7'h0F, 16'h8004, "rd1_status_done");
        rd(7'h10, 16'hBEEF, "rd1_word0");
        rd(7'h11, 16'hDEAD, "rd1_word1");
        rd(7'h12, 16'h0000, "rd1_word2_oob");
        rd(7'h0F, 16'h0004, "rd1_status_idle");
        resp(8'h55);
        rd(7'h0F, 16'h0004, "stray_resp_status");
        rd(7'h10, 16'hBEEF, "stray_resp_word0");

        // Writes, back-to-back acceptance, port out of range
        cmd(16'h8305, 1'b1, 4'b1000);
        rd(7'h0F, 16'h8004, "wr_issue_status");
        cmd(16'h8101, 1'b1, 4'b0010);
        idle();
        rd(7'h0F, 16'h0004, "wr_back_idle");
        cmd(16'h0400, 1'b0, 4'b0000);
        rd(7'h0F, 16'h4004, "bad_port_err");

        // Command while busy is dropped, original read completes
        cmd(16'h0207, 1'b1, 4'b0100);
        rd(7'h0F, 16'h8004, "err_cleared_on_accept");
        cmd(16'h8000, 1'b0, 4'b0000);
        rd(7'h0F, 16'hC000, "busy_reject_status");
        resp(8'h01);
        resp(8'h23);
        resp(8'h45);
        resp(8'h67);
        idle();
        rd(7'h10, 16'h4567, "rd2_word0");
        rd(7'h11, 16'h0123, "rd2_word1");
        rd(7'h0F, 16'h4004, "rd2_status");

        // Flow staging and hash
        for (int k = 0; k < 8; k++) step(1'b1, 7'(48 + k), 16'(16'h1111 * (k + 1)), 1'b0, 8'h0);
        step(1'b1, 7'h03, 16'hFABC, 1'b0, 8'h0);
        @(negedge clk);
        chk("flow_staged", flow, 120'h88_7777_6666_5555_4444_3333_2222_1111);
        idle();
        @(negedge clk);
        chk("hash_staged", hash, 12'hABC);
        ftw(16'h0001, 1'b1, 1'b0);
        ftw(16'h0002, 1'b0, 1'b1);
        ftw(16'h0001, 1'b1, 1'b0);
        ftw(16'h0003, 1'b0, 1'b0);
        idle();
        idle();

        // Asynchronous reset during WAIT
        cmd(16'h0012, 1'b1, 4'b0001);
        idle();
        resp(8'hAA);
        @(posedge clk);
        #1 spi_op = 7'h0F; sys_resp_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_status", spi_dout, 16'h0000);
        chk("mid_rst_req", sys_req_valid, 0);
        chk("mid_rst_flow_hash", {flow, hash}, 0);
        spi_op = 7'h10;
        #1 chk("mid_rst_rdata", spi_dout, 16'h0000);
        @(posedge clk); #1 rst = 1'b0;
        cmd(16'h0155, 1'b1, 4'b0010);
        idle();
        resp(8'h11);
        rd(7'h0F, 16'h8001, "post_rst_cnt");
        resp(8'h22);
        resp(8'h33);
        resp(8'h44);
        idle();
        rd(7'h10, 16'h3344, "post_rst_word0");
        rd(7'h11, 16'h1122, "post_rst_word1");

`ifdef REG_TIMEOUT_EN
        // Stalled read times out after 16 WAIT cycles
        cmd(16'h0333, 1'b1, 4'b1000);
        idle();
        resp(8'h9A);
        resp(8'hBC);
        for (int i = 0; i < 13; i++) idle();
        rd(7'h0F, 16'h8002, "tmo_last_wait");
        rd(7'h0F, 16'h6002, "tmo_status");
        rd(7'h10, 16'h3344, "tmo_rdata_kept");
        cmd(16'h8000, 1'b1, 4'b0001);
        rd(7'h0F, 16'h8002, "tmo_cleared");
`endif

        for (int i = 0; i < 4; i++) idle();
        chk("req_queue_drained", req_q.size(), 0);
        chk("ft_queue_drained", ft_q.size(), 0);
        chk("ack_queue_drained", ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
